// File: rtl/fifo_pkg.sv
// Shared helpers for the capture-path FIFO: level width, pointer wrap and
// read-mode selectors.
package fifo_pkg;

    localparam int unsigned FIFO_STD  = 0;
    localparam int unsigned FIFO_FWFT = 1;

    // Bits needed to hold every occupancy value 0..depth inclusive.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Advance a pointer, wrapping from depth-1 back to 0 (depth need not be 2^n).
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for sync_fifo_ctrl: one synchronous write port, one
// asynchronous read address. Kept separate so it can be swapped for block RAM.
module fifo_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 256,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller for the I2C monitor capture path: pointers,
// occupancy level, threshold/error flags and standard or FWFT read mode.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned FWFT       = FIFO_STD,
    parameter int unsigned AF_LEVEL   = DEPTH - 4,
    parameter int unsigned AE_LEVEL   = 4,
    localparam int unsigned LW        = level_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [LW-1:0]         level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned PW = $clog2(DEPTH);

    if (DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH) begin : g_param_check
        $fatal(1, "sync_fifo_ctrl: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  rd_acc, wr_acc, ram_we;
    logic                  empty_w, full_w;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign empty_w = (level_q == '0);
    assign full_w  = (level_q == LW'(DEPTH));

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    // Accept decisions and next state; clr overrides both requests.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        rd_acc = rd_en & ~empty_w;
        // A pop in the same cycle frees the slot a write into a full FIFO needs.
        wr_acc = wr_en & (~full_w | rd_acc);
        ram_we = wr_acc & ~clr;

        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (rd_acc) begin
                rd_ptr_d   = PW'(next_ptr(32'(rd_ptr_q), DEPTH));
                rd_data_d  = ram_rdata;
                rd_valid_d = 1'b1;
            end
            if (wr_acc) begin
                wr_ptr_d = PW'(next_ptr(32'(wr_ptr_q), DEPTH));
            end
            if (wr_acc && !rd_acc) begin
                level_d = level_q + LW'(1);
            end else if (rd_acc && !wr_acc) begin
                level_d = level_q - LW'(1);
            end
            if (wr_en && !wr_acc) begin
                overflow_d = 1'b1;
            end
            if (rd_en && empty_w) begin
                underflow_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // Head entry shown directly; once empty, the last popped word is held
        // so rd_data still reads 0 after reset rather than stale array contents.
        assign rd_data  = empty_w ? rd_data_q : ram_rdata;
        assign rd_valid = ~empty_w;
    end else begin : g_std
        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (level_q >= LW'(AF_LEVEL));
    assign almost_empty = (level_q <= LW'(AE_LEVEL));
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: a standard-mode DEPTH=5 instance and
// an FWFT DEPTH=8 instance share one stimulus stream and are each compared
// against a queue-based reference model.
module tb_sync_fifo_ctrl;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] wr_data;

    logic [15:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic        full_a, full_b, empty_a, empty_b;
    logic        almost_full_a, almost_full_b, almost_empty_a, almost_empty_b;
    logic        overflow_a, overflow_b, underflow_a, underflow_b;
    logic [2:0]  level_a;
    logic [3:0]  level_b;

    int tests_run;
    int tests_failed;

    sync_fifo_ctrl #(
        .DATA_WIDTH (16),
        .DEPTH      (5),
        .FWFT       (0),
        .AF_LEVEL   (4),
        .AE_LEVEL   (1)
    ) u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data_a),
        .rd_valid     (rd_valid_a),
        .full         (full_a),
        .empty        (empty_a),
        .almost_full  (almost_full_a),
        .almost_empty (almost_empty_a),
        .level        (level_a),
        .overflow     (overflow_a),
        .underflow    (underflow_a)
    );

    sync_fifo_ctrl #(
        .DATA_WIDTH (16),
        .DEPTH      (8),
        .FWFT       (1),
        .AF_LEVEL   (6),
        .AE_LEVEL   (2)
    ) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data_b),
        .rd_valid     (rd_valid_b),
        .full         (full_b),
        .empty        (empty_b),
        .almost_full  (almost_full_b),
        .almost_empty (almost_empty_b),
        .level        (level_b),
        .overflow     (overflow_b),
        .underflow    (underflow_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 = instance A, 1 = instance B.
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int          mdepth [2] = '{5, 8};
    int          maf    [2] = '{4, 6};
    int          mae    [2] = '{1, 2};
    bit          mfwft  [2] = '{1'b0, 1'b1};
    bit          movf   [2];
    bit          munf   [2];
    bit          mval   [2];
    logic [15:0] mlast  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        for (int i = 0; i < 2; i++) begin
            movf[i]  = 1'b0;
            munf[i]  = 1'b0;
            mval[i]  = 1'b0;
            mlast[i] = '0;
        end
    endtask

    task automatic model_edge(input int i, input bit w, input bit r, input bit c, input logic [15:0] d);
        logic [15:0] q[$];
        bit racc;
        bit wacc;
        if (i == 0) q = qa; else q = qb;
        if (c) begin
            q.delete();
            movf[i] = 1'b0;
            munf[i] = 1'b0;
            mval[i] = 1'b0;
        end else begin
            racc = r && (q.size() > 0);
            wacc = w && ((q.size() < mdepth[i]) || racc);
            if (r && !racc) munf[i] = 1'b1;
            if (w && !wacc) movf[i] = 1'b1;
            mval[i] = racc;
            if (racc) mlast[i] = q.pop_front();
            if (wacc) q.push_back(d);
        end
        if (i == 0) qa = q; else qb = q;
    endtask

    task automatic check_inst(input string nm, input int i, input logic [31:0] lvl,
                              input logic f, input logic e, input logic af, input logic ae,
                              input logic ov, input logic un, input logic v,
                              input logic [15:0] dat);
        int n;
        logic [15:0] head;
        if (i == 0) begin
            n    = qa.size();
            head = (n > 0) ? qa[0] : '0;
        end else begin
            n    = qb.size();
            head = (n > 0) ? qb[0] : '0;
        end
        chk({nm, ".level"},        lvl, n);
        chk({nm, ".full"},         f,   n == mdepth[i]);
        chk({nm, ".empty"},        e,   n == 0);
        chk({nm, ".almost_full"},  af,  n >= maf[i]);
        chk({nm, ".almost_empty"}, ae,  n <= mae[i]);
        chk({nm, ".overflow"},     ov,  movf[i]);
        chk({nm, ".underflow"},    un,  munf[i]);
        if (mfwft[i]) begin
            chk({nm, ".rd_valid"}, v, n > 0);
            if (n > 0) chk({nm, ".rd_data"}, dat, head);
        end else begin
            chk({nm, ".rd_valid"}, v, mval[i]);
            chk({nm, ".rd_data"},  dat, mlast[i]);
        end
    endtask

    task automatic check_all();
        check_inst("A", 0, level_a, full_a, empty_a, almost_full_a, almost_empty_a,
                   overflow_a, underflow_a, rd_valid_a, rd_data_a);
        check_inst("B", 1, level_b, full_b, empty_b, almost_full_b, almost_empty_b,
                   overflow_b, underflow_b, rd_valid_b, rd_data_b);
    endtask

    // Drive on the falling edge, let one rising edge happen, check on the next falling edge.
    task automatic step(input bit w, input bit r, input bit c, input logic [15:0] d);
        wr_en   = w;
        rd_en   = r;
        clr     = c;
        wr_data = d;
        @(posedge clk);
        model_edge(0, w, r, c, d);
        model_edge(1, w, r, c, d);
        @(negedge clk);
        check_all();
    endtask

    logic [15:0] exp_drain [5];
    logic [15:0] exp_word;
    int          wpct;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n   = 1'b0;
        clr     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
        chk("reset_empty_a",  empty_a, 1'b1);
        chk("reset_rdata_a",  rd_data_a, 16'h0000);

        // Fill then drain.
        for (int k = 1; k <= 5; k++) step(1'b1, 1'b0, 1'b0, 16'(k));
        chk("fill_full_a",  full_a, 1'b1);
        chk("fill_level_a", level_a, 5);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b1, 1'b0, '0);
            chk("drain_valid_a", rd_valid_a, 1'b1);
            chk("drain_data_a",  rd_data_a, k);
        end
        step(1'b0, 1'b0, 1'b0, '0);
        chk("drain_valid_end_a", rd_valid_a, 1'b0);
        chk("drain_empty_a",     empty_a, 1'b1);

        // Preload three, then ten simultaneous read/write cycles across the wrap.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 16'h00A0 + 16'(k));
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0010 + 16'(k));
            exp_word = (k < 3) ? 16'h00A0 + 16'(k) : 16'h0010 + 16'(k - 3);
            chk("wrap_level_a", level_a, 3);
            chk("wrap_valid_a", rd_valid_a, 1'b1);
            chk("wrap_data_a",  rd_data_a, exp_word);
        end

        // Full with simultaneous pop, then a dropped write.
        step(1'b1, 1'b0, 1'b0, 16'h0020);
        step(1'b1, 1'b0, 1'b0, 16'h0021);
        chk("pre_full_a", full_a, 1'b1);
        step(1'b1, 1'b1, 1'b0, 16'h00AA);
        chk("fullpop_level_a", level_a, 5);
        chk("fullpop_ovf_a",   overflow_a, 1'b0);
        chk("fullpop_data_a",  rd_data_a, 16'h0017);
        step(1'b1, 1'b0, 1'b0, 16'h00BB);
        chk("drop_ovf_a",   overflow_a, 1'b1);
        chk("drop_level_a", level_a, 5);
        exp_drain = '{16'h0018, 16'h0019, 16'h0020, 16'h0021, 16'h00AA};
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b0, '0);
            chk("drop_drain_a", rd_data_a, exp_drain[k]);
        end

        // Underflow, pointer integrity, then clear.
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("unf_a",       underflow_a, 1'b1);
        chk("unf_b",       underflow_b, 1'b1);
        chk("unf_level_a", level_a, 0);
        step(1'b1, 1'b0, 1'b0, 16'h0055);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("unf_ptr_a", rd_data_a, 16'h0055);
        step(1'b0, 1'b0, 1'b1, '0);
        chk("clr_unf_a",   underflow_a, 1'b0);
        chk("clr_ovf_a",   overflow_a, 1'b0);
        chk("clr_level_a", level_a, 0);

        // FWFT: first word visible without rd_en, pop drops rd_valid.
        step(1'b1, 1'b0, 1'b0, 16'h1234);
        chk("fwft_valid_b", rd_valid_b, 1'b1);
        chk("fwft_data_b",  rd_data_b, 16'h1234);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("fwft_pop_b",   rd_valid_b, 1'b0);

        // Thresholds on B.
        step(1'b0, 1'b0, 1'b1, '0);
        for (int k = 1; k <= 7; k++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0300 + 16'(k));
            chk("thr_ae_b", almost_empty_b, k <= 2);
            chk("thr_af_b", almost_full_b,  k >= 6);
        end

        // Asynchronous reset in the middle of a burst, checked before any edge.
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 16'h0777;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_level_a", level_a, 0);
        chk("arst_level_b", level_b, 0);
        chk("arst_empty_b", empty_b, 1'b1);
        chk("arst_full_a",  full_a, 1'b0);
        chk("arst_ae_b",    almost_empty_b, 1'b1);
        chk("arst_af_b",    almost_full_b, 1'b0);
        chk("arst_rdata_b", rd_data_b, 16'h0000);
        check_all();
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // Randomized traffic, alternating write-heavy and read-heavy phases.
        for (int c = 0; c < 600; c++) begin
            wpct = ((c / 100) % 2 == 0) ? 70 : 30;
            step($urandom_range(0, 99) < wpct,
                 $urandom_range(0, 99) < (100 - wpct),
                 $urandom_range(0, 99) < 2,
                 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
